// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Instruction-set definitions shared by the encoder, the
//               control unit and the decode stage.
//               Contents:
//               - mnemonic enumeration (mnem_e)
//               - 6-bit opcode constants
//               - instruction-word field positions
//               - encoder state type
//               - branch classification helper
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

  // Mnemonic index as presented by the program-loader front end.
  typedef enum logic [4:0] {
    M_NOP  = 5'd0,
    M_ADD  = 5'd1,
    M_SUB  = 5'd2,
    M_AND  = 5'd3,
    M_OR   = 5'd4,
    M_NOR  = 5'd5,
    M_XOR  = 5'd6,
    M_SLA  = 5'd7,
    M_SLL  = 5'd8,
    M_SRA  = 5'd9,
    M_SRL  = 5'd10,
    M_ADDI = 5'd11,
    M_SUBI = 5'd12,
    M_LD   = 5'd13,
    M_ST   = 5'd14,
    M_BEZ  = 5'd15,
    M_BNE  = 5'd16,
    M_JMP  = 5'd17,
    M_SWP  = 5'd18
  } mnem_e;

  // 6-bit opcodes placed in word bits [31:26].
  localparam logic [5:0] c_OPC_NOP  = 6'b000000;
  localparam logic [5:0] c_OPC_ADD  = 6'b000001;
  localparam logic [5:0] c_OPC_SUB  = 6'b000011;
  localparam logic [5:0] c_OPC_AND  = 6'b000101;
  localparam logic [5:0] c_OPC_OR   = 6'b000110;
  localparam logic [5:0] c_OPC_NOR  = 6'b000111;
  localparam logic [5:0] c_OPC_XOR  = 6'b001000;
  localparam logic [5:0] c_OPC_SLA  = 6'b001001;
  localparam logic [5:0] c_OPC_SLL  = 6'b001010;
  localparam logic [5:0] c_OPC_SRA  = 6'b001011;
  localparam logic [5:0] c_OPC_SRL  = 6'b001100;
  localparam logic [5:0] c_OPC_ADDI = 6'b100000;
  localparam logic [5:0] c_OPC_SUBI = 6'b100001;
  localparam logic [5:0] c_OPC_LD   = 6'b100100;
  localparam logic [5:0] c_OPC_ST   = 6'b100101;
  localparam logic [5:0] c_OPC_BEZ  = 6'b101000;
  localparam logic [5:0] c_OPC_BNE  = 6'b101001;
  localparam logic [5:0] c_OPC_JMP  = 6'b101010;
  localparam logic [5:0] c_OPC_SWP  = 6'b111111;

  // Least-significant bit of each instruction-word field.
  localparam int c_OPC_LSB = 26;  // [31:26]
  localparam int c_A_LSB   = 21;  // [25:21]
  localparam int c_B_LSB   = 16;  // [20:16]
  localparam int c_C_LSB   = 11;  // [15:11]
  localparam int c_IMM_LSB = 0;   // [15:0]

  // Encoder sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_PAD   = 2'd2,
    S_FULL  = 2'd3
  } enc_state_e;

  // Control-transfer instructions that need a branch-shadow pad.
  function automatic logic is_branch(input logic [4:0] op);
    return (op == M_BEZ) || (op == M_BNE) || (op == M_JMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_word_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_pack
// Description : Combinational mapping of a mnemonic record to a 32-bit
//               instruction word.
//               Ports:
//                 i_op[4:0]    mnemonic index
//                 i_dest[4:0]  destination register
//                 i_src1[4:0]  source register 1
//                 i_src2[4:0]  source register 2 / store value
//                 i_imm[15:0]  immediate / branch offset
//                 o_word[31:0] encoded word (0 for NOP and illegal ops)
//                 o_illegal    op index outside the mnemonic table
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_pack
  import instr_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_dest,
  input  logic [4:0]  i_src1,
  input  logic [4:0]  i_src2,
  input  logic [15:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  // Operand layout selectors.
  localparam logic [2:0] c_FMT_ZERO = 3'd0;  // all operand bits zero
  localparam logic [2:0] c_FMT_R    = 3'd1;  // dest, src1, src2
  localparam logic [2:0] c_FMT_I    = 3'd2;  // dest, src1, imm
  localparam logic [2:0] c_FMT_ST   = 3'd3;  // src2, src1, imm
  localparam logic [2:0] c_FMT_BEZ  = 3'd4;  // 0, src1, imm
  localparam logic [2:0] c_FMT_BNE  = 3'd5;  // src2, src1, imm
  localparam logic [2:0] c_FMT_JMP  = 3'd6;  // 0, 0, imm
  localparam logic [2:0] c_FMT_SWP  = 3'd7;  // dest, src1, 0

  logic [5:0]  w_opc;
  logic [2:0]  w_fmt;
  logic [4:0]  w_a;
  logic [4:0]  w_b;
  logic [15:0] w_lo;

  always_comb begin
    w_opc     = c_OPC_NOP;
    w_fmt     = c_FMT_ZERO;
    o_illegal = 1'b0;
    case (i_op)
      M_NOP:  begin w_opc = c_OPC_NOP;  w_fmt = c_FMT_ZERO; end
      M_ADD:  begin w_opc = c_OPC_ADD;  w_fmt = c_FMT_R;    end
      M_SUB:  begin w_opc = c_OPC_SUB;  w_fmt = c_FMT_R;    end
      M_AND:  begin w_opc = c_OPC_AND;  w_fmt = c_FMT_R;    end
      M_OR:   begin w_opc = c_OPC_OR;   w_fmt = c_FMT_R;    end
      M_NOR:  begin w_opc = c_OPC_NOR;  w_fmt = c_FMT_R;    end
      M_XOR:  begin w_opc = c_OPC_XOR;  w_fmt = c_FMT_R;    end
      M_SLA:  begin w_opc = c_OPC_SLA;  w_fmt = c_FMT_R;    end
      M_SLL:  begin w_opc = c_OPC_SLL;  w_fmt = c_FMT_R;    end
      M_SRA:  begin w_opc = c_OPC_SRA;  w_fmt = c_FMT_R;    end
      M_SRL:  begin w_opc = c_OPC_SRL;  w_fmt = c_FMT_R;    end
      M_ADDI: begin w_opc = c_OPC_ADDI; w_fmt = c_FMT_I;    end
      M_SUBI: begin w_opc = c_OPC_SUBI; w_fmt = c_FMT_I;    end
      M_LD:   begin w_opc = c_OPC_LD;   w_fmt = c_FMT_I;    end
      M_ST:   begin w_opc = c_OPC_ST;   w_fmt = c_FMT_ST;   end
      M_BEZ:  begin w_opc = c_OPC_BEZ;  w_fmt = c_FMT_BEZ;  end
      M_BNE:  begin w_opc = c_OPC_BNE;  w_fmt = c_FMT_BNE;  end
      M_JMP:  begin w_opc = c_OPC_JMP;  w_fmt = c_FMT_JMP;  end
      M_SWP:  begin w_opc = c_OPC_SWP;  w_fmt = c_FMT_SWP;  end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_lo = '0;
    case (w_fmt)
      c_FMT_R:   begin w_a = i_dest; w_b = i_src1; w_lo = {i_src2, 11'd0}; end
      c_FMT_I:   begin w_a = i_dest; w_b = i_src1; w_lo = i_imm; end
      c_FMT_ST:  begin w_a = i_src2; w_b = i_src1; w_lo = i_imm; end
      c_FMT_BEZ: begin w_b = i_src1; w_lo = i_imm; end
      c_FMT_BNE: begin w_a = i_src2; w_b = i_src1; w_lo = i_imm; end
      c_FMT_JMP: begin w_lo = i_imm; end
      c_FMT_SWP: begin w_a = i_dest; w_b = i_src1; end
      default:   begin end
    endcase
  end

  // The C field occupies the top of the immediate slot, so w_lo carries both.
  assign o_word = (32'(w_opc) << c_OPC_LSB)
                | (32'(w_a)   << c_A_LSB)
                | (32'(w_b)   << c_B_LSB)
                | (32'(w_lo)  << c_IMM_LSB);

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts mnemonic records, encodes them and writes the words
//               sequentially into instruction memory, optionally following
//               each branch/jump with NOP_PAD zero words.
//               Ports:
//                 clk, rst            clock / synchronous active-high reset
//                 in_valid, in_ready  record handshake
//                 in_op/dest/src1/src2/imm  record fields
//                 mem_w_en, mem_addr, mem_wdata  memory write port
//                 word_count          words written since reset
//                 full                DEPTH words written (sticky)
//                 err_illegal         one-cycle pulse for a rejected op
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256,
  parameter int                NOP_PAD   = 1,
  localparam int               CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_dest,
  input  logic [4:0]        in_src1,
  input  logic [4:0]        in_src2,
  input  logic [15:0]       in_imm,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CW-1:0]     word_count,
  output logic              full,
  output logic              err_illegal
);

  localparam logic [CW-1:0]     c_DEPTH_CNT = CW'(DEPTH);
  localparam logic [2:0]        c_PAD_N     = 3'(NOP_PAD);
  localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(4);

  enc_state_e        r_state;
  logic              r_w_en;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_count;
  logic              r_err;
  logic              r_branch;
  logic [2:0]        r_pad_cnt;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic [CW-1:0]     w_count_nxt;

  instr_word_pack u_pack (
    .i_op      (in_op),
    .i_dest    (in_dest),
    .i_src1    (in_src1),
    .i_src2    (in_src2),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // Count after the word currently on the write port lands.
  assign w_count_nxt = r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_w_en    <= 1'b0;
      r_wdata   <= '0;
      r_addr    <= BASE_ADDR;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_branch  <= 1'b0;
      r_pad_cnt <= '0;
    end else begin
      r_err <= 1'b0;

      // Address and count follow every completed write, word or pad alike.
      if (r_w_en) begin
        r_addr  <= r_addr + c_ADDR_STEP;
        r_count <= w_count_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state  <= S_WRITE;
              r_w_en   <= 1'b1;
              r_wdata  <= w_word;
              r_branch <= is_branch(in_op);
            end
          end
        end

        S_WRITE: begin
          // Padding is skipped when the branch word itself fills memory.
          if (r_branch && (c_PAD_N != 3'd0) && (w_count_nxt != c_DEPTH_CNT)) begin
            r_state   <= S_PAD;
            r_wdata   <= '0;
            r_pad_cnt <= 3'd1;
          end else if (w_count_nxt == c_DEPTH_CNT) begin
            r_state <= S_FULL;
            r_w_en  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_w_en  <= 1'b0;
          end
        end

        S_PAD: begin
          if (w_count_nxt == c_DEPTH_CNT) begin
            r_state <= S_FULL;
            r_w_en  <= 1'b0;
          end else if (r_pad_cnt == c_PAD_N) begin
            r_state <= S_IDLE;
            r_w_en  <= 1'b0;
          end else begin
            r_pad_cnt <= r_pad_cnt + 3'd1;
          end
        end

        S_FULL: begin
          r_w_en <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_w_en  <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst kills a strobe already on the port when reset arrives
  // mid-write, and holds in_ready low for the whole reset period.
  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign mem_w_en    = r_w_en && !rst;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign word_count  = r_count;
  assign full        = (r_state == S_FULL);
  assign err_illegal = r_err;

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes mnemonic-level instruction records into 32-bit instruction words, the inverse of the opcode decoder used by the control unit.
- Writes each encoded word into instruction memory through a write port.
- Sits between the testbench/program-loader front end and the instruction memory; used to load programs before the pipeline is released.
- Optionally pads branch/jump instructions with NOP words so programs respect the pipeline's branch shadow.

Parameters:
- ADDR_W, 32, width of instruction-memory byte address
- BASE_ADDR, 0, byte address of first written word
- DEPTH, 256, maximum number of words (including pads) the block may write
- NOP_PAD, 1, number of NOP words emitted after each BEZ/BNE/JMP (0..7)

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input record valid
- in_ready  out  1  block can accept a record this cycle
- in_op  in  5  mnemonic index (package enum)
- in_dest  in  5  destination register
- in_src1  in  5  source register 1
- in_src2  in  5  source register 2 / store-value register
- in_imm  in  16  immediate / branch offset
- mem_w_en  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  byte address of word being written
- mem_wdata  out  32  encoded instruction word
- word_count  out  clog2(DEPTH+1)  words written since reset
- full  out  1  DEPTH words written; sticky until rst
- err_illegal  out  1  one-cycle pulse: accepted record had in_op > 18

Behaviour:
- Reset values:
  - in_ready=0 during rst, 1 on the first cycle after rst deasserts.
  - mem_w_en=0, mem_wdata=0, mem_addr=BASE_ADDR, word_count=0, full=0, err_illegal=0.
  - FSM returns to IDLE.
- Accept: handshake completes when in_valid && in_ready on a rising edge.
- Latency: the encoded word appears on mem_wdata with mem_w_en=1 in the cycle after acceptance; mem_w_en is high for exactly one cycle per word.
- mem_addr holds the address of the current word; it advances by 4 after each write and wraps modulo 2^ADDR_W.
- Word layout (bit ranges):
  - [31:26] opcode
  - [25:21] field A
  - [20:16] field B
  - [15:11] field C / [15:0] imm
- Opcodes (6-bit):
  - NOP 000000, ADD 000001, SUB 000011, AND 000101, OR 000110, NOR 000111, XOR 001000
  - SLA 001001, SLL 001010, SRA 001011, SRL 001100
  - ADDI 100000, SUBI 100001, LD 100100, ST 100101
  - BEZ 101000, BNE 101001, JMP 101010, SWP 111111
- Field rules:
  - R-type (ADD..SRL): A=dest, B=src1, C=src2, [10:0]=0.
  - ADDI/SUBI/LD: A=dest, B=src1, imm.
  - ST: A=src2, B=src1, imm.
  - BEZ: A=0, B=src1, imm.
  - BNE: A=src2, B=src1, imm.
  - JMP: A=B=0, imm.
  - SWP: A=dest, B=src1, [15:0]=0 (single word; the decoder expands it into two cycles).
  - NOP: all 32 bits zero regardless of other inputs.
- FSM states: IDLE, WRITE, PAD, FULL.
  - IDLE: in_ready=1. On accept of a legal op, go to WRITE. On accept of an illegal op, pulse err_illegal next cycle, write nothing, stay IDLE.
  - WRITE: one cycle, mem_w_en=1, in_ready=0.
    - If the op was a branch and NOP_PAD>0, go to PAD.
    - Else if the written word brings word_count to DEPTH, go to FULL.
    - Else go to IDLE.
  - PAD: emit NOP_PAD consecutive zero words, one per cycle, mem_w_en=1, in_ready=0. Then go to IDLE, or to FULL if DEPTH is reached. If DEPTH is reached mid-pad, stop padding and go to FULL.
  - FULL: full=1, in_ready=0, no writes until rst.
- Back-to-back records produce at most one word per two cycles (IDLE→WRITE→IDLE).
- in_* inputs are sampled only at acceptance; later changes have no effect on the word.
- rst mid-WRITE/PAD: the write in that cycle is suppressed, all outputs take reset values, and the in-flight record is lost.

Decomposition:
- Shared package instr_pkg:
  - mnemonic enum (NOP=0, ADD=1, SUB=2, AND=3, OR=4, NOR=5, XOR=6, SLA=7, SLL=8, SRA=9, SRL=10, ADDI=11, SUBI=12, LD=13, ST=14, BEZ=15, BNE=16, JMP=17, SWP=18).
  - 6-bit opcode constants.
  - field bit-position constants; shared with the control unit and the decode stage.
- One combinational sub-module, instr_word_pack: maps (op, dest, src1, src2, imm) to a word plus an illegal flag.
- FSM, address and count logic live in instr_encoder.

Test Plan:
- rst high 3 cycles, then low → in_ready=1, mem_addr=0, word_count=0, no mem_w_en.
- Accept ADD dest=3 src1=1 src2=2 → next cycle mem_w_en=1, mem_addr=0, mem_wdata=0x04611000; then mem_addr=4, word_count=1.
- Accept ADDI dest=5 src1=0 imm=0xFFFF, then ST src1=2 src2=7 imm=8 → words 0x80A0FFFF at 0 and 0x94E20008 at 4.
- NOP_PAD=2: accept BEZ src1=4 imm=0x0010 → three consecutive writes: 0xA0040010, 0x00000000, 0x00000000; in_ready=0 for those 3 cycles.
- Accept in_op=25 → err_illegal pulses once, no write, word_count unchanged, in_ready stays 1.
- DEPTH=4, NOP_PAD=1: write 3 ADDs, then JMP imm=5 → JMP written at addr 12, pad suppressed, full=1, in_ready=0; further in_valid ignored. Then rst → full=0, mem_addr=0.
